// File: rtl/display_frame_sync_pkg.sv
// ---------------------------------------------------------------------------
// display_frame_sync_pkg : shared playfield types and constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package display_frame_sync_pkg;

  localparam int FIELD_W        = 10;
  localparam int FIELD_H        = 22;  // 20 visible rows plus 2 hidden spawn rows
  localparam int V_ACTIVE_LINES = 800;

  typedef logic [2:0] cell_t;

  localparam cell_t TETROMINO_EMPTY = 3'd0;
  localparam cell_t TETROMINO_I     = 3'd1;
  localparam cell_t TETROMINO_O     = 3'd2;
  localparam cell_t TETROMINO_T     = 3'd3;
  localparam cell_t TETROMINO_S     = 3'd4;
  localparam cell_t TETROMINO_Z     = 3'd5;
  localparam cell_t TETROMINO_J     = 3'd6;
  localparam cell_t TETROMINO_L     = 3'd7;

  typedef cell_t [FIELD_H-1:0][FIELD_W-1:0] field_t;

  typedef struct packed {
    cell_t      kind;
    logic [1:0] rot;
  } tetromino_ctrl;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } sync_state_e;

  function automatic field_t empty_field();
    field_t f;
    for (int r = 0; r < FIELD_H; r++) begin
      for (int c = 0; c < FIELD_W; c++) begin
        f[r][c] = TETROMINO_EMPTY;
      end
    end
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_frame_sync_if.sv
// ---------------------------------------------------------------------------
// display_frame_sync_if : snapshot offer handshake from game logic
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface display_frame_sync_if;
  import display_frame_sync_pkg::*;

  logic          upd_valid;
  logic          upd_ready;
  field_t        upd_field;
  logic [31:0]   upd_score;
  tetromino_ctrl upd_next;
  logic [3:0]    upd_level;
  logic          upd_game_over;
  logic          upd_done;

  modport master (
    output upd_valid, upd_field, upd_score, upd_next, upd_level, upd_game_over,
    input  upd_ready, upd_done
  );

  modport slave (
    input  upd_valid, upd_field, upd_score, upd_next, upd_level, upd_game_over,
    output upd_ready, upd_done
  );

endinterface

`default_nettype wire

// File: rtl/display_frame_sync_vblank_edge.sv
// ---------------------------------------------------------------------------
// vblank_edge : registered one-cycle pulse at the start of vertical blanking
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vblank_edge #(
  parameter int V_ACTIVE = 800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] curr_y,
  output logic       frame_tick
);

  localparam logic [9:0] V_ACTIVE_L = 10'(V_ACTIVE);

  logic in_vb;
  logic in_vb_q;
  logic frame_tick_q;

  assign in_vb = (curr_y >= V_ACTIVE_L);

  // in_vb_q starts high so leaving reset inside blanking is not seen as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vb_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      in_vb_q      <= in_vb;
      frame_tick_q <= in_vb & ~in_vb_q;
    end
  end

  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: rtl/display_frame_sync.sv
// ---------------------------------------------------------------------------
// display_frame_sync : stages game snapshots and commits them at vblank start;
//                      owns the frame counter and the game-over blink
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module display_frame_sync
  import display_frame_sync_pkg::*;
#(
  parameter int V_ACTIVE     = V_ACTIVE_LINES,
  parameter int BLINK_FRAMES = 30,
  parameter int FCNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            curr_y,
  display_frame_sync_if.slave   upd,
  output field_t                disp_field,
  output logic [31:0]           disp_score,
  output tetromino_ctrl         disp_next,
  output logic [3:0]            disp_level,
  output logic                  disp_game_over,
  output logic                  frame_tick,
  output logic [FCNT_W-1:0]     frame_cnt,
  output logic                  blink_on
);

  localparam int                BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  sync_state_e   state_q;
  logic          ready_q;
  logic          done_q;

  field_t        stg_field_q;
  logic [31:0]   stg_score_q;
  tetromino_ctrl stg_next_q;
  logic [3:0]    stg_level_q;
  logic          stg_game_over_q;

  field_t        disp_field_q;
  logic [31:0]   disp_score_q;
  tetromino_ctrl disp_next_q;
  logic [3:0]    disp_level_q;
  logic          disp_game_over_q;

  logic [FCNT_W-1:0]  frame_cnt_q;
  logic [FCNT_W-1:0]  frame_cnt_d;
  logic [BLINK_W-1:0] blink_div_q;
  logic               blink_on_q;
  logic               tick;

  vblank_edge #(
    .V_ACTIVE (V_ACTIVE)
  ) u_vblank_edge (
    .clk        (clk),
    .rst        (rst),
    .curr_y     (curr_y),
    .frame_tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      ready_q          <= 1'b1;
      done_q           <= 1'b0;
      stg_field_q      <= empty_field();
      stg_score_q      <= '0;
      stg_next_q       <= '0;
      stg_level_q      <= '0;
      stg_game_over_q  <= 1'b0;
      disp_field_q     <= empty_field();
      disp_score_q     <= '0;
      disp_next_q      <= '0;
      disp_level_q     <= '0;
      disp_game_over_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (upd.upd_valid) begin
            stg_field_q     <= upd.upd_field;
            stg_score_q     <= upd.upd_score;
            stg_next_q      <= upd.upd_next;
            stg_level_q     <= upd.upd_level;
            stg_game_over_q <= upd.upd_game_over;
            ready_q         <= 1'b0;
            state_q         <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (tick) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // tick was one cycle ago, so this copy always lands inside blanking
          disp_field_q     <= stg_field_q;
          disp_score_q     <= stg_score_q;
          disp_next_q      <= stg_next_q;
          disp_level_q     <= stg_level_q;
          disp_game_over_q <= stg_game_over_q;
          done_q           <= 1'b1;
          ready_q          <= 1'b1;
          state_q          <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign frame_cnt_d = frame_cnt_q + FCNT_W'(tick);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      blink_div_q <= '0;
      blink_on_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      if (!disp_game_over_q) begin
        blink_div_q <= '0;
        blink_on_q  <= 1'b0;
      end else if (tick) begin
        if (blink_div_q == BLINK_LAST) begin
          blink_div_q <= '0;
          blink_on_q  <= ~blink_on_q;
        end else begin
          blink_div_q <= blink_div_q + 1'b1;
        end
      end
    end
  end

  assign upd.upd_ready  = ready_q;
  assign upd.upd_done   = done_q;
  assign disp_field     = disp_field_q;
  assign disp_score     = disp_score_q;
  assign disp_next      = disp_next_q;
  assign disp_level     = disp_level_q;
  assign disp_game_over = disp_game_over_q;
  assign frame_tick     = tick;
  assign frame_cnt      = frame_cnt_q;
  assign blink_on       = blink_on_q;

endmodule

`default_nettype wire

// File: tb/tb_display_frame_sync.sv
// ---------------------------------------------------------------------------
// tb_display_frame_sync : directed self-checking bench for display_frame_sync
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_display_frame_sync;
  import display_frame_sync_pkg::*;

  localparam int FCNT_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        curr_y;
  field_t            disp_field;
  logic [31:0]       disp_score;
  tetromino_ctrl     disp_next;
  logic [3:0]        disp_level;
  logic              disp_game_over;
  logic              frame_tick;
  logic [FCNT_W-1:0] frame_cnt;
  logic              blink_on;

  int checks = 0;
  int errors = 0;

  display_frame_sync_if u_if ();

  display_frame_sync #(
    .V_ACTIVE     (800),
    .BLINK_FRAMES (2),
    .FCNT_W       (FCNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .curr_y         (curr_y),
    .upd            (u_if),
    .disp_field     (disp_field),
    .disp_score     (disp_score),
    .disp_next      (disp_next),
    .disp_level     (disp_level),
    .disp_game_over (disp_game_over),
    .frame_tick     (frame_tick),
    .frame_cnt      (frame_cnt),
    .blink_on       (blink_on)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the cycle where frame_tick is high
  task automatic vblank();
    curr_y = 10'd100;
    step();
    curr_y = 10'd800;
    step();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] score, input logic go);
    u_if.upd_valid     = 1'b1;
    u_if.upd_score     = score;
    u_if.upd_game_over = go;
  endtask

  initial begin
    rst                = 1'b1;
    curr_y             = 10'd810;
    u_if.upd_valid     = 1'b0;
    u_if.upd_field     = empty_field();
    u_if.upd_score     = '0;
    u_if.upd_next      = '0;
    u_if.upd_level     = '0;
    u_if.upd_game_over = 1'b0;

    // 1. reset released inside blanking
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_spurious_tick", frame_tick, 0);
    end
    check("rst_disp_score", disp_score, 0);
    check("rst_ready", u_if.upd_ready, 1);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_done", u_if.upd_done, 0);
    check("rst_blink", blink_on, 0);
    checks++;
    assert (disp_field === empty_field()) else begin
      errors++;
      $error("FAIL rst_field observed %h expected all-empty", disp_field);
    end

    // 2. basic offer, commit two cycles after frame_tick
    curr_y = 10'd100;
    step();
    u_if.upd_field[0][0] = TETROMINO_T;
    u_if.upd_level       = 4'd3;
    offer(32'd1234, 1'b0);
    step();
    u_if.upd_valid = 1'b0;
    check("t2_ready_drop", u_if.upd_ready, 0);
    step();
    step();
    check("t2_hold_active", disp_score, 0);
    curr_y = 10'd800;
    step();
    check("t2_tick", frame_tick, 1);
    check("t2_not_yet", disp_score, 0);
    step();
    check("t2_tick_pulse", frame_tick, 0);
    check("t2_cnt", frame_cnt, 1);
    check("t2_done_early", u_if.upd_done, 0);
    step();
    check("t2_score", disp_score, 1234);
    check("t2_level", disp_level, 3);
    check("t2_field", disp_field[0][0], TETROMINO_T);
    check("t2_done", u_if.upd_done, 1);
    check("t2_ready_back", u_if.upd_ready, 1);
    step();
    check("t2_done_pulse", u_if.upd_done, 0);

    // 3. second offer stalls while one is pending
    offer(32'd5, 1'b0);
    step();
    u_if.upd_score = 32'd9;
    check("t3_ready_stall", u_if.upd_ready, 0);
    step();
    step();
    vblank();
    step();
    step();
    check("t3_first", disp_score, 5);
    check("t3_first_done", u_if.upd_done, 1);
    step();
    u_if.upd_valid = 1'b0;
    check("t3_second_taken", u_if.upd_ready, 0);
    check("t3_still_first", disp_score, 5);
    vblank();
    step();
    step();
    check("t3_second", disp_score, 9);
    check("t3_cnt", frame_cnt, 3);

    // 4. offer presented while frame_tick is high waits a whole frame
    vblank();
    offer(32'd42, 1'b0);
    step();
    u_if.upd_valid = 1'b0;
    check("t4_accepted", u_if.upd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_done", u_if.upd_done, 0);
    end
    check("t4_not_this_frame", disp_score, 9);
    vblank();
    step();
    step();
    check("t4_next_frame", disp_score, 42);
    check("t4_done", u_if.upd_done, 1);

    // 5. blink with BLINK_FRAMES=2
    offer(32'd100, 1'b1);
    step();
    u_if.upd_valid = 1'b0;
    vblank();
    step();
    step();
    check("t5_go_visible", disp_game_over, 1);
    check("t5_blink_start", blink_on, 0);
    vblank(); step(); check("t5_blink_f1", blink_on, 0);
    vblank(); step(); check("t5_blink_f2", blink_on, 1);
    vblank(); step(); check("t5_blink_f3", blink_on, 1);
    vblank(); step(); check("t5_blink_f4", blink_on, 0);
    vblank(); step(); check("t5_blink_f5", blink_on, 0);
    vblank(); step(); check("t5_blink_f6", blink_on, 1);
    offer(32'd200, 1'b0);
    step();
    u_if.upd_valid = 1'b0;
    vblank();
    step();
    step();
    check("t5_go_cleared", disp_game_over, 0);
    step();
    check("t5_blink_off", blink_on, 0);
    check("t5_cnt", frame_cnt, 13);

    // 6. reset while pending discards the snapshot; frame counter wraps
    offer(32'd77, 1'b0);
    step();
    u_if.upd_valid = 1'b0;
    check("t6_pending", u_if.upd_ready, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("t6_disp_score", disp_score, 0);
    check("t6_ready", u_if.upd_ready, 1);
    check("t6_cnt_reset", frame_cnt, 0);
    vblank();
    step();
    step();
    check("t6_no_done", u_if.upd_done, 0);
    check("t6_score_stays", disp_score, 0);
    check("t6_cnt_one", frame_cnt, 1);
    for (int i = 0; i < 4094; i++) begin
      vblank();
    end
    step();
    check("t6_cnt_max", frame_cnt, 4095);
    vblank();
    step();
    check("t6_cnt_wrap", frame_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
